pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 4, total multiply latency in cycles (legal range 2..63).
REQ-002 SHALL provide parameter DIV_CYCLES, default 32, total divide latency in cycles (legal range 2..63).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port idEx_memRead  input  1  instruction in EX is a load.
REQ-006 SHALL have port idEx_rt  input  5  load destination register in EX.
REQ-007 SHALL have port ifId_rs  input  5  rs of instruction in ID.
REQ-008 SHALL have port ifId_rt  input  5  rt of instruction in ID.
REQ-009 SHALL have port ifId_usesRt  input  1  ID instruction reads rt as a source.
REQ-010 SHALL have port ifId_readsHiLo  input  1  ID instruction is mfhi/mflo.
REQ-011 SHALL have port ifId_isMd  input  1  ID instruction is mult/multu/div/divu.
REQ-012 SHALL have port md_start  input  1  mult/div issuing from EX this cycle.
REQ-013 SHALL have port md_isDiv  input  1  qualifies md_start: 1 = divide, 0 = multiply.
REQ-014 SHALL have port branchTaken  input  1  branch/jump resolved taken in ID.
REQ-015 SHALL have port pcEnable  output  1  write enable for PC register.
REQ-016 SHALL have port ifIdEnable  output  1  write enable for IF/ID pipeline register.
REQ-017 SHALL have port idExBubble  output  1  forces ID/EX control fields to NOP.
REQ-018 SHALL have port ifIdFlush  output  1  clears IF/ID to NOP.
REQ-019 SHALL have port mdBusy  output  1  mult/div unit in progress.
REQ-020 SHALL have port mdDone  output  1  one-cycle pulse; HI/LO written this cycle.

Function
REQ-021 SHALL compute loadUse = idEx_memRead & (idEx_rt != 0) & ((idEx_rt == ifId_rs) | (ifId_usesRt & idEx_rt == ifId_rt)).
REQ-022 SHALL compute mdHazard = mdBusy & (ifId_readsHiLo | ifId_isMd).
REQ-023 SHALL define stall = loadUse | mdHazard; pcEnable = ifIdEnable = ~stall; idExBubble = stall (combinational, same cycle).
REQ-024 SHALL drive ifIdFlush = branchTaken & ~stall; stall has priority, branch re-evaluated when stall clears.
REQ-025 SHALL implement FSM states IDLE, BUSY, DONE with a 6-bit down-counter.
REQ-026 IDLE: md_start -> BUSY, counter loaded with (md_isDiv ? DIV_CYCLES : MULT_CYCLES) - 2.
REQ-027 BUSY: counter != 0 -> decrement, stay; counter == 0 -> DONE.
REQ-028 DONE: md_start -> BUSY (back-to-back, counter reloaded per REQ-026); else -> IDLE.
REQ-029 For md_start in cycle 0: mdBusy high cycles 1..N-1, mdDone high exactly cycle N, N = selected latency.
REQ-030 mdBusy = (state == BUSY); mdDone = (state == DONE); both registered-state decodes, no glitch paths from inputs.
REQ-031 md_start while BUSY SHALL be ignored (state and counter unchanged); bench flags it as protocol error.
REQ-032 In DONE cycle mdHazard SHALL be 0 (mfhi/mflo in ID proceeds; reads HI/LO in EX next cycle).
REQ-033 loadUse and mdHazard simultaneously SHALL produce a single stall; no extra bubble.

Reset
REQ-034 RST high SHALL asynchronously force state IDLE, counter 0, hence mdBusy 0, mdDone 0.
REQ-035 During/after reset, with inputs idle: pcEnable 1, ifIdEnable 1, idExBubble 0, ifIdFlush 0.
REQ-036 Reset mid-operation SHALL abort the pending mult/div; no mdDone pulse follows.

Structure
REQ-037 FSM state encodings and MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared MIPS definitions include file.
REQ-038 Counter + BUSY/DONE FSM SHALL be one sub-module md_latency_counter; hazard logic stays in the top.

Verification
REQ-039 idEx_memRead=1, idEx_rt=8, ifId_rs=8 -> pcEnable=0, ifIdEnable=0, idExBubble=1 same cycle; idEx_rt=0 same pattern -> no stall.
REQ-040 md_start=1, md_isDiv=0 at cycle 0 -> mdBusy cycles 1-3, mdDone cycle 4 only; md_isDiv=1 -> mdDone cycle 32.
REQ-041 ifId_readsHiLo=1 held from cycle 1 after multiply start -> stall cycles 1-3, pcEnable=1 at cycle 4.
REQ-042 branchTaken=1 with loadUse=1 -> ifIdFlush=0; next cycle loadUse=0, branchTaken=1 -> ifIdFlush=1.
REQ-043 RST pulse at cycle 10 of a divide -> mdBusy 0 immediately, no mdDone in following 40 cycles.
REQ-044 md_start in DONE cycle of multiply -> mdBusy next cycle, second mdDone exactly 4 cycles after second start.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared MIPS pipeline-control definitions: multiply/divide FSM encodings,
// latency defaults and field widths.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 6;

  localparam int unsigned MULT_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // BUSY covers cycles 1..N-1 and counts down to zero, so N-2 is loaded
  function automatic logic [CNT_W-1:0] md_load(input int unsigned cycles);
    return CNT_W'(cycles - 2);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_md_latency_counter.sv
// Multiply/divide latency tracker: IDLE/BUSY/DONE FSM with a 6-bit down-counter.
// Busy and done are plain decodes of the state register.
module md_latency_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic md_start,
  input  logic md_isDiv,
  output logic mdBusy,
  output logic mdDone
);

  localparam logic [CNT_W-1:0] MULT_LOAD = md_load(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = md_load(DIV_CYCLES);

  md_state_e        state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;

  assign load_val = md_isDiv ? DIV_LOAD : MULT_LOAD;

  // A start seen while BUSY is dropped: state and counter hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            state <= MD_BUSY;
            count <= load_val;
          end
        end
        MD_BUSY: begin
          if (count == '0) begin
            state <= MD_DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        MD_DONE: begin
          if (md_start) begin
            state <= MD_BUSY;
            count <= load_val;
          end else begin
            state <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign mdBusy = (state == MD_BUSY);
  assign mdDone = (state == MD_DONE);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard unit: load-use and HI/LO-busy stalls, branch flush, and the
// multiply/divide latency tracker.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             idEx_memRead,
  input  logic [REG_W-1:0] idEx_rt,
  input  logic [REG_W-1:0] ifId_rs,
  input  logic [REG_W-1:0] ifId_rt,
  input  logic             ifId_usesRt,
  input  logic             ifId_readsHiLo,
  input  logic             ifId_isMd,
  input  logic             md_start,
  input  logic             md_isDiv,
  input  logic             branchTaken,
  output logic             pcEnable,
  output logic             ifIdEnable,
  output logic             idExBubble,
  output logic             ifIdFlush,
  output logic             mdBusy,
  output logic             mdDone
);

  logic load_use;
  logic md_hazard;
  logic stall;

  md_latency_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_latency_counter (
    .CLK     (CLK),
    .RST     (RST),
    .md_start(md_start),
    .md_isDiv(md_isDiv),
    .mdBusy  (mdBusy),
    .mdDone  (mdDone)
  );

  // $zero is never a real dependency
  assign load_use = idEx_memRead && (idEx_rt != '0) &&
                    ((idEx_rt == ifId_rs) || (ifId_usesRt && (idEx_rt == ifId_rt)));

  // DONE is excluded: HI/LO are written this cycle, so a reader in ID may advance
  assign md_hazard = mdBusy && (ifId_readsHiLo || ifId_isMd);

  assign stall = load_use || md_hazard;

  // Stall wins over flush; the branch is seen again once the stall drops
  assign pcEnable   = ~stall;
  assign ifIdEnable = ~stall;
  assign idExBubble = stall;
  assign ifIdFlush  = branchTaken && !stall;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: hazard vectors, mult/div latency,
// back-to-back issue and reset abort, all against hand-derived expectations.
module tb_pipeline_stall_ctrl;

  logic       CLK;
  logic       RST;
  logic       idEx_memRead;
  logic [4:0] idEx_rt;
  logic [4:0] ifId_rs;
  logic [4:0] ifId_rt;
  logic       ifId_usesRt;
  logic       ifId_readsHiLo;
  logic       ifId_isMd;
  logic       md_start;
  logic       md_isDiv;
  logic       branchTaken;
  logic       pcEnable;
  logic       ifIdEnable;
  logic       idExBubble;
  logic       ifIdFlush;
  logic       mdBusy;
  logic       mdDone;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       stall;
  } lu_vec_t;

  lu_vec_t lu_tab [7];

  pipeline_stall_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .idEx_memRead  (idEx_memRead),
    .idEx_rt       (idEx_rt),
    .ifId_rs       (ifId_rs),
    .ifId_rt       (ifId_rt),
    .ifId_usesRt   (ifId_usesRt),
    .ifId_readsHiLo(ifId_readsHiLo),
    .ifId_isMd     (ifId_isMd),
    .md_start      (md_start),
    .md_isDiv      (md_isDiv),
    .branchTaken   (branchTaken),
    .pcEnable      (pcEnable),
    .ifIdEnable    (ifIdEnable),
    .idExBubble    (idExBubble),
    .ifIdFlush     (ifIdFlush),
    .mdBusy        (mdBusy),
    .mdDone        (mdDone)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are changed 1 time unit after a rising edge, well clear of it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp_stall);
    check_bit({tag, "_pc"}, pcEnable, !exp_stall);
    check_bit({tag, "_ifid"}, ifIdEnable, !exp_stall);
    check_bit({tag, "_bub"}, idExBubble, exp_stall);
  endtask

  task automatic clear_hazards();
    idEx_memRead   = 1'b0;
    idEx_rt        = 5'd0;
    ifId_rs        = 5'd0;
    ifId_rt        = 5'd0;
    ifId_usesRt    = 1'b0;
    ifId_readsHiLo = 1'b0;
    ifId_isMd      = 1'b0;
    branchTaken    = 1'b0;
  endtask

  initial begin
    lu_tab[0] = '{1'b1, 5'd8,  5'd8, 5'd0, 1'b0, 1'b1};
    lu_tab[1] = '{1'b1, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0};
    lu_tab[2] = '{1'b0, 5'd8,  5'd8, 5'd0, 1'b0, 1'b0};
    lu_tab[3] = '{1'b1, 5'd8,  5'd3, 5'd8, 1'b1, 1'b1};
    lu_tab[4] = '{1'b1, 5'd8,  5'd3, 5'd8, 1'b0, 1'b0};
    lu_tab[5] = '{1'b1, 5'd31, 5'd31, 5'd5, 1'b0, 1'b1};
    lu_tab[6] = '{1'b1, 5'd5,  5'd6, 5'd7, 1'b1, 1'b0};

    RST      = 1'b1;
    md_start = 1'b0;
    md_isDiv = 1'b0;
    clear_hazards();

    // Reset state with idle inputs
    #3;
    check_bit("rst_busy", mdBusy, 1'b0);
    check_bit("rst_done", mdDone, 1'b0);
    check_stall("rst", 1'b0);
    check_bit("rst_flush", ifIdFlush, 1'b0);
    @(posedge CLK);
    #2 RST = 1'b0;

    // Load-use table, FSM idle
    for (int i = 0; i < 7; i++) begin
      tick();
      idEx_memRead = lu_tab[i].mr;
      idEx_rt      = lu_tab[i].ert;
      ifId_rs      = lu_tab[i].rs;
      ifId_rt      = lu_tab[i].rt;
      ifId_usesRt  = lu_tab[i].ur;
      #1;
      check_stall($sformatf("lu%0d", i), lu_tab[i].stall);
    end
    tick();
    clear_hazards();

    // Multiply: busy 1..3, done 4; mfhi held from cycle 1 stalls 1..3
    tick();
    md_start = 1'b1;
    md_isDiv = 1'b0;
    #1;
    check_bit("mul_c0_busy", mdBusy, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      md_start       = 1'b0;
      ifId_readsHiLo = (c <= 5);
      // load-use coinciding with the HI/LO hazard must still be one stall
      idEx_memRead   = (c == 2);
      idEx_rt        = (c == 2) ? 5'd8 : 5'd0;
      ifId_rs        = (c == 2) ? 5'd8 : 5'd0;
      #1;
      check_bit($sformatf("mul_c%0d_busy", c), mdBusy, (c <= 3));
      check_bit($sformatf("mul_c%0d_done", c), mdDone, (c == 4));
      check_stall($sformatf("mul_c%0d", c), (c <= 3));
    end
    clear_hazards();

    // Divide: busy 1..31, done 32; stray start at cycle 5 is ignored
    tick();
    md_start = 1'b1;
    md_isDiv = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      md_start  = (c == 5);
      md_isDiv  = (c != 5);
      ifId_isMd = (c == 10) || (c == 32);
      #1;
      check_bit($sformatf("div_c%0d_busy", c), mdBusy, (c <= 31));
      check_bit($sformatf("div_c%0d_done", c), mdDone, (c == 32));
      if (c == 10 || c == 32) check_stall($sformatf("div_c%0d", c), (c == 10));
    end
    clear_hazards();
    md_isDiv = 1'b0;

    // Branch flush is held off by a load-use stall, then fires
    tick();
    idEx_memRead = 1'b1;
    idEx_rt      = 5'd8;
    ifId_rs      = 5'd8;
    branchTaken  = 1'b1;
    #1;
    check_bit("br_stall_flush", ifIdFlush, 1'b0);
    check_bit("br_stall_pc", pcEnable, 1'b0);
    tick();
    idEx_memRead = 1'b0;
    #1;
    check_bit("br_go_flush", ifIdFlush, 1'b1);
    check_bit("br_go_pc", pcEnable, 1'b1);
    tick();
    branchTaken = 1'b0;
    #1;
    check_bit("br_off_flush", ifIdFlush, 1'b0);
    clear_hazards();

    // Reset at cycle 10 of a divide aborts it
    tick();
    md_start = 1'b1;
    md_isDiv = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      md_start = 1'b0;
    end
    #1;
    check_bit("abort_pre_busy", mdBusy, 1'b1);
    RST = 1'b1;
    #1;
    check_bit("abort_busy", mdBusy, 1'b0);
    check_bit("abort_done", mdDone, 1'b0);
    #1 RST = 1'b0;
    md_isDiv = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_bit($sformatf("abort_c%0d_done", c), mdDone, 1'b0);
    end

    // Back-to-back multiply: second start in the DONE cycle
    tick();
    md_start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      md_start = (c == 4);
      #1;
      check_bit($sformatf("b2b_c%0d_busy", c), mdBusy, (c <= 3) || (c >= 5 && c <= 7));
      check_bit($sformatf("b2b_c%0d_done", c), mdDone, (c == 4) || (c == 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
